// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: payload + control word with valid/ready,
// hazard stall, synchronous flush, optional skid entry and saturating perf counters.

module pipe_stage_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

module pipe_stage_elastic #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 10,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic              in_fire, out_fire, m_load;

    assign out_fire = m_valid & out_ready & ~stall;
    assign in_fire  = in_valid & in_ready;
    // M takes a new beat (or empties) whenever it is free or its beat leaves.
    assign m_load   = ~m_valid | out_fire;

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: only the skid entry's occupancy gates the input.
            assign in_ready = ~reset & ~s_valid;

            always_ff @(posedge clk) begin
                if (reset || flush || m_load) begin
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_ctrl  <= '0;
                end else if (in_fire) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                    s_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_noskid
            assign in_ready = ~reset & m_load;
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (m_load) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end else begin
                m_valid <= 1'b0;
                m_data  <= '0;
                m_ctrl  <= '0;
            end
        end
    end

    // Empty slots read as all-zero so a bubble acts as a NOP downstream.
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data : '0;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    pipe_stage_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~m_valid),
        .count (bubble_cnt)
    );

    pipe_stage_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & (m_valid | s_valid | in_fire)),
        .count (flush_cnt)
    );

endmodule
